// File: rtl/mriscv_pkg.sv
// Shared load/store definitions: func3 access-size encodings, memory-stage FSM
// states and the alignment predicate used when MEMORY_ACCESS_MISALIGN_TRAP_EN is set.
package mriscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } mem_state_e;

    // Reserved encodings (011/110/111) behave as word accesses.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr);
        case (f3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return addr[0];
            default:     return addr != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane steering: store strobes/replicated write data and
// load-lane extraction with sign or zero extension.
module mem_align
    import mriscv_pkg::*;
(
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [31:0] lane;

    always_comb begin
        wstrb_o     = 4'b1111;
        wdata_o     = store_data_i;
        lane        = rdata_i;
        load_data_o = lane;
        case (func3_i)
            F3_B, F3_BU: begin
                wstrb_o     = 4'b0001 << addr_i;
                wdata_o     = {4{store_data_i[7:0]}};
                lane        = rdata_i >> {addr_i, 3'b000};
                load_data_o = (func3_i == F3_B) ? {{24{lane[7]}}, lane[7:0]}
                                                : {24'h000000, lane[7:0]};
            end
            F3_H, F3_HU: begin
                // Halfword lane selected by addr[1] only; addr[0] never shifts.
                wstrb_o     = 4'b0011 << {addr_i[1], 1'b0};
                wdata_o     = {2{store_data_i[15:0]}};
                lane        = rdata_i >> {addr_i[1], 4'b0000};
                load_data_o = (func3_i == F3_H) ? {{16{lane[15]}}, lane[15:0]}
                                                : {16'h0000, lane[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory stage of the pipeline: pass-through of ALU results, single-outstanding
// bus loads/stores with a MAX_WAIT timeout. Define MEMORY_ACCESS_MISALIGN_TRAP_EN
// to trap misaligned H/W accesses on an extra 'misaligned' output.
module memory_access
    import mriscv_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  func3,
    input  logic [31:0] result_i,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_i,
    output logic [31:0] wb_data,
    output logic [4:0]  dest_o,
    output logic        valid_o,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    output logic        misaligned,
`endif
    output logic        bus_err
);

    localparam logic [7:0] MAX_W8 = MAX_WAIT[7:0];

    mem_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  dest_q, dest_d;
    logic        we_q, we_d;
    logic        valid_q, valid_d;
    logic [31:0] wb_q, wb_d;
    logic [4:0]  desto_q, desto_d;
    logic        err_q, err_d;
    logic        mis_q, mis_d;

    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    mem_align u_align (
        .func3_i      (f3_q),
        .addr_i       (addr_q[1:0]),
        .store_data_i (sdata_q),
        .rdata_i      (mem_rdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .load_data_o  (al_load)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sdata_d = sdata_q;
        f3_d    = f3_q;
        dest_d  = dest_q;
        we_d    = we_q;
        valid_d = 1'b0;
        wb_d    = 32'h0;
        desto_d = 5'd0;
        err_d   = 1'b0;
        mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (is_load || is_store) begin
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
                        if (is_misaligned(func3, result_i[1:0])) begin
                            valid_d = 1'b1;
                            mis_d   = 1'b1;
                        end else
`endif
                        begin
                            addr_d  = result_i;
                            sdata_d = store_data;
                            f3_d    = func3;
                            dest_d  = dest_i;
                            we_d    = is_store;
                            cnt_d   = 8'd0;
                            state_d = BUS;
                        end
                    end else begin
                        valid_d = 1'b1;
                        wb_d    = result_i;
                        desto_d = dest_i;
                    end
                end
            end
            BUS: begin
                // Ack is tested first so it wins over a simultaneous timeout.
                if (mem_ack) begin
                    valid_d = 1'b1;
                    state_d = IDLE;
                    if (!we_q) begin
                        wb_d    = al_load;
                        desto_d = dest_q;
                    end
                end else if (cnt_q + 8'd1 == MAX_W8) begin
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 32'h0;
            sdata_q <= 32'h0;
            f3_q    <= 3'b000;
            dest_q  <= 5'd0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            wb_q    <= 32'h0;
            desto_q <= 5'd0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sdata_q <= sdata_d;
            f3_q    <= f3_d;
            dest_q  <= dest_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            wb_q    <= wb_d;
            desto_q <= desto_d;
            err_q   <= err_d;
            mis_q   <= mis_d;
        end
    end

    assign ready_o   = (state_q == IDLE);
    assign mem_req   = (state_q == BUS);
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = al_wdata;
    assign mem_wstrb = mem_we ? al_wstrb : 4'b0000;
    assign valid_o   = valid_q;
    assign wb_data   = wb_q;
    assign dest_o    = desto_q;
    assign bus_err   = err_q;
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    assign misaligned = mis_q;
`else
    logic unused_mis;
    assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access (MAX_WAIT=4).
module tb_memory_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i, ready_o, is_load, is_store;
    logic [2:0]  func3;
    logic [31:0] result_i, store_data, wb_data, mem_addr, mem_wdata, mem_rdata;
    logic [4:0]  dest_i, dest_o;
    logic        valid_o, mem_req, mem_we, mem_ack, bus_err;
    logic [3:0]  mem_wstrb;
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
    logic        misaligned;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] cap_addr, cap_wdata, r_wb;
    logic [3:0]  cap_wstrb;
    logic        cap_we, cap_rdy, stable;
    logic        r_valid, r_err, r_req, r_rdy;
    logic [4:0]  r_dest;
    logic [1:0]  r_after;
    int          bus_cycles;

    memory_access #(.MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .is_load    (is_load),
        .is_store   (is_store),
        .func3      (func3),
        .result_i   (result_i),
        .store_data (store_data),
        .dest_i     (dest_i),
        .wb_data    (wb_data),
        .dest_o     (dest_o),
        .valid_o    (valid_o),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
`ifdef MEMORY_ACCESS_MISALIGN_TRAP_EN
        .misaligned (misaligned),
`endif
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one load/store, ack on BUS cycle ack_at (0 = never), capture results.
    task automatic run_mem(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sd,
                           input logic [4:0] dst, input int ack_at, input logic [31:0] rd);
        int  n;
        logic done;
        valid_i = 1'b1; is_load = ld; is_store = st; func3 = f3;
        result_i = addr; store_data = sd; dest_i = dst;
        @(negedge clk);
        valid_i = 1'b0; is_load = 1'b0; is_store = 1'b0;
        result_i = 32'hFFFF_FFFC; store_data = ~sd; dest_i = 5'd31;
        cap_addr = mem_addr; cap_we = mem_we; cap_wstrb = mem_wstrb;
        cap_wdata = mem_wdata; cap_rdy = ready_o;
        stable = 1'b1; n = 0; done = 1'b0;
        while (!done && n < 16) begin
            n++;
            if (mem_req !== 1'b1 || mem_addr !== cap_addr || mem_we !== cap_we ||
                mem_wstrb !== cap_wstrb || mem_wdata !== cap_wdata) stable = 1'b0;
            if (n == ack_at) begin
                mem_ack = 1'b1; mem_rdata = rd;
            end
            @(negedge clk);
            mem_ack = 1'b0; mem_rdata = 32'h0;
            done = valid_o | bus_err;
        end
        bus_cycles = n;
        r_valid = valid_o; r_wb = wb_data; r_dest = dest_o; r_err = bus_err;
        r_req = mem_req; r_rdy = ready_o;
        @(negedge clk);
        r_after = {valid_o, bus_err};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; valid_i = 1'b0; is_load = 1'b0; is_store = 1'b0;
        func3 = 3'b000; result_i = 32'h0; store_data = 32'h0; dest_i = 5'd0;
        mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ready", {31'h0, ready_o}, 32'd1);
        check_val("rst_valid", {31'h0, valid_o}, 32'd0);
        check_val("rst_req", {31'h0, mem_req}, 32'd0);
        check_val("rst_err", {31'h0, bus_err}, 32'd0);
        check_val("rst_wb", wb_data, 32'h0);
        check_val("rst_addr", mem_addr, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Pass-through
        valid_i = 1'b1; result_i = 32'd40; dest_i = 5'd10;
        @(negedge clk);
        valid_i = 1'b0;
        check_val("pt_valid", {31'h0, valid_o}, 32'd1);
        check_val("pt_wb", wb_data, 32'd40);
        check_val("pt_dest", {27'h0, dest_o}, 32'd10);
        check_val("pt_req", {31'h0, mem_req}, 32'd0);
        @(negedge clk);
        check_val("pt_pulse", {31'h0, valid_o}, 32'd0);

        // Ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("idle_ack_valid", {31'h0, valid_o}, 32'd0);
        check_val("idle_ack_ready", {31'h0, ready_o}, 32'd1);

        // LW, ack on third BUS cycle
        run_mem(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 3, 32'hDEAD_BEEF);
        check_val("lw_addr", cap_addr, 32'h100);
        check_val("lw_we", {31'h0, cap_we}, 32'd0);
        check_val("lw_busy", {31'h0, cap_rdy}, 32'd0);
        check_val("lw_stable", {31'h0, stable}, 32'd1);
        check_val("lw_cycles", bus_cycles, 32'd3);
        check_val("lw_valid", {31'h0, r_valid}, 32'd1);
        check_val("lw_wb", r_wb, 32'hDEAD_BEEF);
        check_val("lw_dest", {27'h0, r_dest}, 32'd5);
        check_val("lw_req_after", {31'h0, r_req}, 32'd0);
        check_val("lw_ready_after", {31'h0, r_rdy}, 32'd1);
        check_val("lw_pulse", {30'h0, r_after}, 32'd0);

        // LB / LBU lane 3
        run_mem(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 1, 32'h80FF_0000);
        check_val("lb_addr", cap_addr, 32'h100);
        check_val("lb_wb", r_wb, 32'hFFFF_FF80);
        check_val("lb_dest", {27'h0, r_dest}, 32'd6);
        run_mem(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 2, 32'h80FF_0000);
        check_val("lbu_wb", r_wb, 32'h0000_0080);

        // LH / LHU
        run_mem(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 5'd8, 1, 32'h8001_1234);
        check_val("lh_wb", r_wb, 32'hFFFF_8001);
        run_mem(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 5'd8, 1, 32'h8001_1234);
        check_val("lhu_wb", r_wb, 32'h0000_1234);

        // SH upper half
        run_mem(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_ABCD, 5'd9, 2, 32'h0);
        check_val("sh_addr", cap_addr, 32'h200);
        check_val("sh_wstrb", {28'h0, cap_wstrb}, 32'b1100);
        check_val("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        check_val("sh_we", {31'h0, cap_we}, 32'd1);
        check_val("sh_stable", {31'h0, stable}, 32'd1);
        check_val("sh_valid", {31'h0, r_valid}, 32'd1);
        check_val("sh_dest", {27'h0, r_dest}, 32'd0);
        check_val("sh_wb", r_wb, 32'h0);

        // SB lane 1, SW
        run_mem(1'b0, 1'b1, 3'b000, 32'h101, 32'h7777_775A, 5'd9, 1, 32'h0);
        check_val("sb_wstrb", {28'h0, cap_wstrb}, 32'b0010);
        check_val("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
        run_mem(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 5'd9, 1, 32'h0);
        check_val("sw_wstrb", {28'h0, cap_wstrb}, 32'b1111);
        check_val("sw_wdata", cap_wdata, 32'hCAFE_F00D);

`ifndef MEMORY_ACCESS_MISALIGN_TRAP_EN
        // Without trapping, low address bits are ignored for H and W
        run_mem(1'b1, 1'b0, 3'b001, 32'h103, 32'h0, 5'd3, 1, 32'h8001_1234);
        check_val("lh_odd_wb", r_wb, 32'hFFFF_8001);
        run_mem(1'b1, 1'b0, 3'b011, 32'h101, 32'h0, 5'd3, 1, 32'h1357_9BDF);
        check_val("lw011_wb", r_wb, 32'h1357_9BDF);
`else
        valid_i = 1'b1; is_load = 1'b1; func3 = 3'b010; result_i = 32'h102; dest_i = 5'd4;
        @(negedge clk);
        valid_i = 1'b0; is_load = 1'b0;
        check_val("mis_flag", {31'h0, misaligned}, 32'd1);
        check_val("mis_valid", {31'h0, valid_o}, 32'd1);
        check_val("mis_dest", {27'h0, dest_o}, 32'd0);
        check_val("mis_wb", wb_data, 32'h0);
        check_val("mis_req", {31'h0, mem_req}, 32'd0);
        @(negedge clk);
        check_val("mis_pulse", {31'h0, misaligned}, 32'd0);
`endif

        // Timeout after 4 BUS cycles
        run_mem(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd7, 0, 32'h0);
        check_val("to_cycles", bus_cycles, 32'd4);
        check_val("to_err", {31'h0, r_err}, 32'd1);
        check_val("to_valid", {31'h0, r_valid}, 32'd1);
        check_val("to_dest", {27'h0, r_dest}, 32'd0);
        check_val("to_req", {31'h0, r_req}, 32'd0);
        check_val("to_ready", {31'h0, r_rdy}, 32'd1);
        check_val("to_pulse", {30'h0, r_after}, 32'd0);

        // Ack on the cycle the counter reaches MAX_WAIT wins
        run_mem(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd7, 4, 32'h2468_ACE0);
        check_val("race_cycles", bus_cycles, 32'd4);
        check_val("race_err", {31'h0, r_err}, 32'd0);
        check_val("race_wb", r_wb, 32'h2468_ACE0);
        check_val("race_dest", {27'h0, r_dest}, 32'd7);

        // Reset mid-BUS
        valid_i = 1'b1; is_load = 1'b1; func3 = 3'b010; result_i = 32'h500; dest_i = 5'd2;
        @(negedge clk);
        valid_i = 1'b0; is_load = 1'b0;
        check_val("mid_req_before", {31'h0, mem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_val("mid_req_async", {31'h0, mem_req}, 32'd0);
        check_val("mid_ready_async", {31'h0, ready_o}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        check_val("mid_no_valid", {31'h0, valid_o}, 32'd0);
        check_val("mid_req_after", {31'h0, mem_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
